// File: rtl/imem_responder_if.sv
// Fetch, response and program-load signals of the instruction-memory responder.
// The slave modport is the responder; the master modport is the fetch stage / loader.
interface imem_responder_if;
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic        Imem2proc_ack;
  logic        proc2Imem_resp_ready;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  logic        Imem2proc_err;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  modport slave (
    input  proc2Imem_req, proc2Imem_addr, proc2Imem_resp_ready,
    input  prog_we, prog_addr, prog_data,
    output Imem2proc_ack, Imem2proc_valid, Imem2proc_data, Imem2proc_err
  );

  modport master (
    output proc2Imem_req, proc2Imem_addr, proc2Imem_resp_ready,
    output prog_we, prog_addr, prog_data,
    input  Imem2proc_ack, Imem2proc_valid, Imem2proc_data, Imem2proc_err
  );
endinterface

// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory responder: read pipeline feeding an in-order response FIFO.
// Optional IMEM_RANGE_CHECK_EN flags out-of-range fetches (NOP + err) and drops out-of-range writes.
module imem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_responder_if.slave  bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]         mem_q [MEM_WORDS];
  logic [AW-1:0]       rd_idx, wr_idx;
  logic                rd_in_range, wr_in_range;
  logic [31:0]         rd_word;
  logic                rd_err;
  logic                ack, accept, valid, pop, push;

  logic [CW-1:0]       occ_q, occ_d;
  logic [LATENCY-1:0]  pv_q;
  logic [LATENCY-1:0]  pe_q;
  logic [31:0]         pd_q [LATENCY];

  logic [31:0]         fd_q [DEPTH];
  logic [DEPTH-1:0]    fe_q;
  logic [PW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;

  assign rd_idx = bus.proc2Imem_addr[AW+1:2];
  assign wr_idx = bus.prog_addr[AW+1:2];

`ifdef IMEM_RANGE_CHECK_EN
  assign rd_in_range = (bus.proc2Imem_addr[31:AW+2] == '0);
  assign wr_in_range = (bus.prog_addr[31:AW+2] == '0);
`else
  assign rd_in_range = 1'b1;
  assign wr_in_range = 1'b1;
`endif

  assign rd_word = rd_in_range ? mem_q[rd_idx] : 32'h0000_0013;
  assign rd_err  = ~rd_in_range;

  // Ack depends only on registered occupancy, never on resp_ready.
  assign ack    = rst_n && (occ_q < CW'(DEPTH));
  assign accept = bus.proc2Imem_req && ack;
  assign valid  = (fcnt_q != '0);
  assign pop    = valid && bus.proc2Imem_resp_ready;
  assign push   = pv_q[LATENCY-1];

  assign bus.Imem2proc_ack   = ack;
  assign bus.Imem2proc_valid = valid;
  assign bus.Imem2proc_data  = valid ? fd_q[rp_q] : 32'h0;
`ifdef IMEM_RANGE_CHECK_EN
  assign bus.Imem2proc_err   = valid & fe_q[rp_q];
`else
  assign bus.Imem2proc_err   = 1'b0;
`endif

  // Array is deliberately unreset so program contents survive rst_n.
  always_ff @(posedge clk) begin
    if (bus.prog_we && wr_in_range) mem_q[wr_idx] <= bus.prog_data;
  end

  always_ff @(posedge clk) begin
    pd_q[0] <= rd_word;
    for (int i = 1; i < LATENCY; i++) pd_q[i] <= pd_q[i-1];
    if (push) begin
      fd_q[wp_q] <= pd_q[LATENCY-1];
      fe_q[wp_q] <= pe_q[LATENCY-1];
    end
  end

  always_comb begin
    occ_d  = occ_q;
    fcnt_d = fcnt_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (accept && !pop) occ_d = occ_q + CW'(1);
    if (pop && !accept) occ_d = occ_q - CW'(1);
    if (push && !pop)   fcnt_d = fcnt_q + CW'(1);
    if (pop && !push)   fcnt_d = fcnt_q - CW'(1);
    if (push) wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
    if (pop)  rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= '0;
      fcnt_q <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      pv_q   <= '0;
      pe_q   <= '0;
    end else begin
      occ_q  <= occ_d;
      fcnt_q <= fcnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      pv_q[0] <= accept;
      pe_q[0] <= rd_err;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder at default parameters (1024 words, LATENCY 2, DEPTH 4).
module tb_imem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  imem_responder_if bus ();

  imem_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_init(input int i);
    return (i == 0) ? 32'hDEAD_BEEF : (32'hA000_0000 + 32'(i));
  endfunction

  initial begin
    bus.proc2Imem_req        = 1'b0;
    bus.proc2Imem_addr       = '0;
    bus.proc2Imem_resp_ready = 1'b1;
    bus.prog_we              = 1'b0;
    bus.prog_addr            = '0;
    bus.prog_data            = '0;

    // Reset state
    step();
    chk("rst_valid", {31'b0, bus.Imem2proc_valid}, 32'd0);
    chk("rst_ack",   {31'b0, bus.Imem2proc_ack},   32'd0);
    chk("rst_data",  bus.Imem2proc_data,           32'd0);
    chk("rst_err",   {31'b0, bus.Imem2proc_err},   32'd0);
    rst_n = 1'b1;
    step();
    chk("ack_after_rst", {31'b0, bus.Imem2proc_ack}, 32'd1);

    // Preload words 0..15
    for (int i = 0; i < 16; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 32'(i * 4);
      bus.prog_data = word_init(i);
      step();
    end
    bus.prog_we = 1'b0;
    chk("prog_no_occ", {31'b0, bus.Imem2proc_ack}, 32'd1);

    // Single fetch of word 0
    bus.proc2Imem_req  = 1'b1;
    bus.proc2Imem_addr = 32'h0;
    step();
    bus.proc2Imem_req = 1'b0;
    chk("single_v_n0", {31'b0, bus.Imem2proc_valid}, 32'd0);
    step();
    chk("single_v_n1", {31'b0, bus.Imem2proc_valid}, 32'd0);
    step();
    chk("single_v_n2", {31'b0, bus.Imem2proc_valid}, 32'd1);
    chk("single_data", bus.Imem2proc_data, 32'hDEAD_BEEF);
    step();
    chk("single_v_n3", {31'b0, bus.Imem2proc_valid}, 32'd0);

    // Streaming: 8 requests, one response per cycle, ack never drops
    for (int j = 0; j < 10; j++) begin
      bus.proc2Imem_req  = (j < 8);
      bus.proc2Imem_addr = 32'(j * 4);
      if (j < 8) chk("stream_ack", {31'b0, bus.Imem2proc_ack}, 32'd1);
      step();
      if (j >= 2) begin
        chk("stream_valid", {31'b0, bus.Imem2proc_valid}, 32'd1);
        chk("stream_data", bus.Imem2proc_data, word_init(j - 2));
      end else begin
        chk("stream_idle", {31'b0, bus.Imem2proc_valid}, 32'd0);
      end
    end
    bus.proc2Imem_req = 1'b0;
    step();
    chk("stream_drained", {31'b0, bus.Imem2proc_valid}, 32'd0);

    // Backpressure: exactly 4 accepts with ready low
    bus.proc2Imem_resp_ready = 1'b0;
    bus.proc2Imem_req        = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.proc2Imem_addr = 32'((4 + k) * 4);
      chk("bp_ack", {31'b0, bus.Imem2proc_ack}, (k < 4) ? 32'd1 : 32'd0);
      step();
      if (k >= 4) begin
        chk("bp_stall_valid", {31'b0, bus.Imem2proc_valid}, 32'd1);
        chk("bp_stall_data", bus.Imem2proc_data, word_init(4));
      end
    end
    bus.proc2Imem_addr       = 32'h20;
    bus.proc2Imem_resp_ready = 1'b1;
    chk("bp_full_ack", {31'b0, bus.Imem2proc_ack}, 32'd0);
    step();
    chk("bp_reack", {31'b0, bus.Imem2proc_ack}, 32'd1);
    chk("bp_data5", bus.Imem2proc_data, word_init(5));
    step();
    bus.proc2Imem_req = 1'b0;
    chk("bp_data6", bus.Imem2proc_data, word_init(6));
    step();
    chk("bp_data7", bus.Imem2proc_data, word_init(7));
    step();
    chk("bp_data8", bus.Imem2proc_data, word_init(8));
    step();
    chk("bp_drained", {31'b0, bus.Imem2proc_valid}, 32'd0);

    // Write/read collision on word 3
    bus.prog_we   = 1'b1;
    bus.prog_addr = 32'hC;
    bus.prog_data = 32'h1111_1111;
    step();
    bus.prog_data      = 32'h2222_2222;
    bus.proc2Imem_req  = 1'b1;
    bus.proc2Imem_addr = 32'hC;
    step();
    bus.prog_we = 1'b0;
    step();
    bus.proc2Imem_req = 1'b0;
    step();
    chk("coll_old", bus.Imem2proc_data, 32'h1111_1111);
    step();
    chk("coll_new", bus.Imem2proc_data, 32'h2222_2222);
    step();

    // Reset mid-stream with 3 outstanding requests
    bus.proc2Imem_resp_ready = 1'b0;
    bus.proc2Imem_req        = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.proc2Imem_addr = 32'(k * 4);
      step();
    end
    bus.proc2Imem_req = 1'b0;
    chk("mid_pre_valid", {31'b0, bus.Imem2proc_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, bus.Imem2proc_valid}, 32'd0);
    chk("mid_rst_ack",   {31'b0, bus.Imem2proc_ack},   32'd0);
    step();
    chk("mid_rst_ack2",  {31'b0, bus.Imem2proc_ack},   32'd0);
    rst_n = 1'b1;
    bus.proc2Imem_resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_no_stale", {31'b0, bus.Imem2proc_valid}, 32'd0);
    end
    chk("mid_ack", {31'b0, bus.Imem2proc_ack}, 32'd1);
    bus.proc2Imem_req  = 1'b1;
    bus.proc2Imem_addr = 32'h4;
    step();
    bus.proc2Imem_req = 1'b0;
    step();
    step();
    chk("mid_fresh", bus.Imem2proc_data, word_init(1));
    step();

    // Range check: fetch of 4*MEM_WORDS
    bus.proc2Imem_req  = 1'b1;
    bus.proc2Imem_addr = 32'h1000;
    step();
    bus.proc2Imem_req = 1'b0;
    step();
    step();
    chk("range_valid", {31'b0, bus.Imem2proc_valid}, 32'd1);
`ifdef IMEM_RANGE_CHECK_EN
    chk("range_data", bus.Imem2proc_data, 32'h0000_0013);
    chk("range_err",  {31'b0, bus.Imem2proc_err}, 32'd1);
`else
    chk("range_data", bus.Imem2proc_data, 32'hDEAD_BEEF);
    chk("range_err",  {31'b0, bus.Imem2proc_err}, 32'd0);
`endif
    step();
    chk("range_drained", {31'b0, bus.Imem2proc_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
